// File: rtl/vga_capture.sv
// Video-input capture: tracks line/frame position from vsync/DE, selects an
// IMG_W x IMG_H window at (IMG_X, IMG_Y) in the active area and writes it,
// one pixel per word, into a frame-buffer RAM. Single-shot or continuous.

module vga_capture #(
    parameter int unsigned IMG_W = 200,
    parameter int unsigned IMG_H = 164,
    parameter int unsigned IMG_X = 0,
    parameter int unsigned IMG_Y = 0
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        vin_hsync,
    input  logic        vin_vsync,
    input  logic        vin_de,
    input  logic [15:0] vin_data,
    input  logic        cap_start,
    input  logic        cap_cont,
    input  logic        cap_stop,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_done,
    output logic        frame_short,
    output logic        cap_busy,
    output logic [15:0] pix_cnt
);

    typedef enum logic [1:0] {StIdle, StArm, StCap, StDone} state_e;

    state_e      state_q;
    logic        cont_q;

    logic        s1_vsync, s1_de, s2_vsync, s2_de;
    logic [15:0] s1_data;
    logic        vs_rise, de_fall;

    logic [10:0] col_q, row_q;
    logic [31:0] col_ext, row_ext;
    logic        in_win, last_row;
    logic [15:0] win_addr;

    // Line tracking is DE-based; hsync is carried only for interface completeness.
    logic unused_hsync;
    assign unused_hsync = vin_hsync;

    // Two-stage input pipeline; s2 exists only for edge detection.
    always_ff @(posedge clk) begin
        if (rest) begin
            s1_vsync <= 1'b0;
            s1_de    <= 1'b0;
            s1_data  <= 16'd0;
            s2_vsync <= 1'b0;
            s2_de    <= 1'b0;
        end else begin
            s1_vsync <= vin_vsync;
            s1_de    <= vin_de;
            s1_data  <= vin_data;
            s2_vsync <= s1_vsync;
            s2_de    <= s1_de;
        end
    end

    assign vs_rise = s1_vsync & ~s2_vsync;
    assign de_fall = ~s1_de & s2_de;

    // Saturating column/row position counters; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rest) begin
            col_q <= 11'd0;
            row_q <= 11'd0;
        end else begin
            if (de_fall) begin
                col_q <= 11'd0;
            end else if (s1_de && col_q != 11'h7FF) begin
                col_q <= col_q + 11'd1;
            end
            if (vs_rise) begin
                row_q <= 11'd0;
            end else if (de_fall && row_q != 11'h7FF) begin
                row_q <= row_q + 11'd1;
            end
        end
    end

    // Window decode and frame-buffer address for the pixel currently in s1.
    always_comb begin
        col_ext  = {21'd0, col_q};
        row_ext  = {21'd0, row_q};
        // "+1 >" form keeps the lower-bound test meaningful when the offset is zero.
        in_win   = s1_de
                   && (col_ext + 32'd1 > IMG_X) && (col_ext < IMG_X + IMG_W)
                   && (row_ext + 32'd1 > IMG_Y) && (row_ext < IMG_Y + IMG_H);
        last_row = (row_ext == IMG_Y + IMG_H - 32'd1);
        win_addr = 16'((row_ext - IMG_Y) * IMG_W + (col_ext - IMG_X));
    end

    // Capture FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (rest) begin
            state_q     <= StIdle;
            cont_q      <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= 16'd0;
            wr_data     <= 16'd0;
            frame_done  <= 1'b0;
            frame_short <= 1'b0;
            cap_busy    <= 1'b0;
            pix_cnt     <= 16'd0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cap_start) begin
                        cont_q   <= cap_cont;
                        cap_busy <= 1'b1;
                        state_q  <= StArm;
                    end
                end
                StArm: begin
                    if (vs_rise) begin
                        pix_cnt <= 16'd0;
                        state_q <= StCap;
                    end
                end
                StCap: begin
                    if (in_win) begin
                        wr_en   <= 1'b1;
                        wr_addr <= win_addr;
                        wr_data <= s1_data;
                        pix_cnt <= pix_cnt + 16'd1;
                    end
                    // A vsync before the last window line ends the frame short; that
                    // vs_rise is consumed here so continuous mode skips the next frame.
                    if (vs_rise) begin
                        frame_done  <= 1'b1;
                        frame_short <= 1'b1;
                        state_q     <= StDone;
                    end else if (de_fall && last_row) begin
                        frame_done  <= 1'b1;
                        frame_short <= 1'b0;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (cont_q && !cap_stop) begin
                        state_q <= StArm;
                    end else begin
                        cap_busy <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    cap_busy <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a miniature timing source:
// 12 clocks/line (8 active), 10 lines/frame (active lines 0..v_act-1, vsync on
// lines 8-9). Pixel data is {line, pixel} so every expected word is computable.

module tb_vga_capture;

    localparam int H_TOT = 12;
    localparam int H_ACT = 8;
    localparam int V_TOT = 10;
    localparam int VS_L  = 8;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int X     = 2;
    localparam int Y     = 1;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic        vin_hsync = 1'b0, vin_vsync = 1'b0, vin_de = 1'b0;
    logic [15:0] vin_data = 16'd0;
    logic        cap_start = 1'b0, cap_cont = 1'b0, cap_stop = 1'b0;
    logic        wr_en, frame_done, frame_short, cap_busy;
    logic [15:0] wr_addr, wr_data, pix_cnt;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int gen_line = 0, gen_pix = 0, gen_frame = 0, v_act = 6;
    int pix_cyc = 0, de_low_cyc = 0;

    logic [15:0] wa[$];
    logic [15:0] wd[$];
    int          wc[$];
    int          df[$];
    int          done_cnt = 0, done_cyc = 0, done_pix = 0;
    logic        done_short = 1'b0;

    vga_capture #(
        .IMG_W(W),
        .IMG_H(H),
        .IMG_X(X),
        .IMG_Y(Y)
    ) dut (
        .clk        (clk),
        .rest       (rest),
        .vin_hsync  (vin_hsync),
        .vin_vsync  (vin_vsync),
        .vin_de     (vin_de),
        .vin_data   (vin_data),
        .cap_start  (cap_start),
        .cap_cont   (cap_cont),
        .cap_stop   (cap_stop),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_short(frame_short),
        .cap_busy   (cap_busy),
        .pix_cnt    (pix_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Timing source: drives the pixel for "cycle cyc" on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            vin_de    = (gen_line < v_act) && (gen_pix < H_ACT);
            vin_data  = vin_de ? {8'(gen_line), 8'(gen_pix)} : 16'd0;
            vin_vsync = (gen_line >= VS_L);
            vin_hsync = (gen_pix >= 9) && (gen_pix < 11);
            if (gen_line == Y && gen_pix == X) pix_cyc = cyc;
            if (gen_line == Y + H - 1 && gen_pix == H_ACT) de_low_cyc = cyc;
            gen_pix++;
            if (gen_pix == H_TOT) begin
                gen_pix = 0;
                gen_line++;
                if (gen_line == V_TOT) begin
                    gen_line = 0;
                    gen_frame++;
                end
            end
        end
    end

    // Output monitor, sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wc.push_back(cyc);
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc   = cyc;
            done_short = frame_short;
            done_pix   = int'(pix_cnt);
            df.push_back(gen_frame);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: sim time exceeded, got timeout required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_pos(input int l, input int p);
        int k = 0;
        while (!(gen_line == l && gen_pix == p) && k < 2000) begin
            tick();
            k++;
        end
        check_eq("wait_pos", 32'(k < 2000), 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            tick();
            k++;
        end
        check_eq("done_wait", done_cnt, target);
    endtask

    task automatic start_cap(input logic cont);
        cap_start = 1'b1;
        cap_cont  = cont;
        tick();
        cap_start = 1'b0;
        cap_cont  = 1'b0;
    endtask

    function automatic logic [15:0] exp_pix(input int i);
        return {8'(Y + i / W), 8'(X + i % W)};
    endfunction

    // Checks n consecutive writes starting at log index base for addr/data.
    task automatic check_writes(input int base, input int n);
        for (int i = 0; i < n && base + i < wa.size(); i++) begin
            check_eq("wr_addr", wa[base + i], 32'(i % (W * H)));
            check_eq("wr_data", wd[base + i], exp_pix(i % (W * H)));
        end
    endtask

    initial begin
        int b0, d0, f0, mark, k;

        // Reset state
        repeat (3) tick();
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_frame_short", frame_short, 0);
        check_eq("rst_cap_busy", cap_busy, 0);
        check_eq("rst_pix_cnt", pix_cnt, 0);
        rest = 1'b0;

        // Single shot, started mid-frame: must wait for the next vsync.
        wait_pos(1, 0);
        b0 = wa.size();
        d0 = done_cnt;
        f0 = gen_frame;
        start_cap(1'b0);
        check_eq("busy_after_start", cap_busy, 1);
        tick();
        start_cap(1'b1);  // ignored outside idle
        wait_done(d0 + 1, 400);
        check_eq("single_nwr", wa.size() - b0, 8);
        check_writes(b0, 8);
        check_eq("single_frame", df[d0], f0 + 1);
        check_eq("single_short", done_short, 0);
        check_eq("single_pix_cnt", done_pix, 8);
        if (wc.size() > b0) check_eq("latency", wc[b0] - pix_cyc, 2);
        check_eq("done_timing", done_cyc - de_low_cyc, 2);
        tick();
        tick();
        check_eq("single_idle", cap_busy, 0);
        repeat (150) tick();
        check_eq("single_one_done", done_cnt, d0 + 1);
        check_eq("single_no_more_wr", wa.size() - b0, 8);

        // Continuous, three frames, stop requested during the third.
        wait_pos(5, 0);
        b0 = wa.size();
        d0 = done_cnt;
        start_cap(1'b1);
        wait_done(d0 + 2, 500);
        wait_pos(1, 0);
        cap_stop = 1'b1;
        wait_done(d0 + 3, 300);
        tick();
        tick();
        check_eq("cont_idle", cap_busy, 0);
        cap_stop = 1'b0;
        repeat (150) tick();
        check_eq("cont_ndone", done_cnt, d0 + 3);
        check_eq("cont_nwr", wa.size() - b0, 24);
        check_writes(b0, 24);
        check_eq("cont_consec1", df[d0 + 1] - df[d0], 1);
        check_eq("cont_consec2", df[d0 + 2] - df[d0 + 1], 1);
        check_eq("cont_pix_cnt", done_pix, 8);

        // Window runs past the active area: short frame ended by vsync.
        wait_pos(3, 0);
        b0 = wa.size();
        d0 = done_cnt;
        start_cap(1'b0);
        wait_pos(9, 0);
        v_act = 2;
        wait_done(d0 + 1, 300);
        check_eq("short_nwr", wa.size() - b0, 4);
        check_writes(b0, 4);
        check_eq("short_flag", done_short, 1);
        check_eq("short_pix_cnt", done_pix, 4);
        repeat (5) tick();
        check_eq("short_hold", frame_short, 1);
        check_eq("short_done_pulse", frame_done, 0);
        wait_pos(9, 0);
        v_act = 6;

        // Reset in the middle of a capture.
        wait_pos(3, 0);
        b0 = wa.size();
        d0 = done_cnt;
        start_cap(1'b0);
        k = 0;
        while (wa.size() - b0 < 2 && k < 400) begin
            tick();
            k++;
        end
        check_eq("mid_wr_seen", 32'(wa.size() - b0 >= 2), 1);
        rest = 1'b1;
        tick();
        rest = 1'b0;
        check_eq("mrst_wr_en", wr_en, 0);
        check_eq("mrst_wr_addr", wr_addr, 0);
        check_eq("mrst_wr_data", wr_data, 0);
        check_eq("mrst_frame_short", frame_short, 0);
        check_eq("mrst_cap_busy", cap_busy, 0);
        check_eq("mrst_pix_cnt", pix_cnt, 0);
        mark = wa.size();
        repeat (250) tick();
        check_eq("mrst_no_wr", wa.size(), mark);
        check_eq("mrst_no_done", done_cnt, d0);
        wait_pos(3, 0);
        b0 = wa.size();
        start_cap(1'b0);
        wait_done(d0 + 1, 400);
        check_eq("post_rst_nwr", wa.size() - b0, 8);
        check_writes(b0, 8);
        check_eq("post_rst_short", done_short, 0);
        check_eq("post_rst_pix_cnt", done_pix, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
